// File: rtl/ucie_d2d_pkg.sv
// Shared types and helpers for the die-to-die channel model.
// Link states, direction indices and the latency clamp.
package ucie_d2d_pkg;

   typedef enum logic [1:0] {
      DOWN  = 2'd0,
      UP    = 2'd1,
      DRAIN = 2'd2
   } link_state_e;

   localparam int DIR_A2B = 0;
   localparam int DIR_B2A = 1;

   // Latency 0 makes no sense for a register line; floor at 1.
   function automatic int clamp_lat(input int req, input int max_lat);
      if (req < 1) return 1;
      else if (req > max_lat) return max_lat;
      else return req;
   endfunction

endpackage

// File: rtl/ucie_d2d_delay_line.sv
// Shift-register delay line with a run-time tap select.
// Ports: clk, rst_n (async low), lat (1..DEPTH), d in, q = stage[lat-1].
module ucie_d2d_delay_line #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int LATW  = $clog2(DEPTH + 1)
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [LATW-1:0] lat,
   input  logic [W-1:0]    d,
   output logic [W-1:0]    q
);

   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   // Tap mux written as a compare chain so the select width never
   // has to match the array index width.
   always_comb begin
      q = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (lat == LATW'(i + 1)) q = stage[i];
      end
   end

endmodule

// File: rtl/ucie_d2d_channel_model.sv
// Two-direction die-to-die channel: programmable delay, link gating,
// drain, one-shot mainband error injection and beat counters.
// Ports: i_clk/i_rst_n, cfg (lat, link_up), side A/B mainband, sideband
// and train in/out (o_a_* = B->A, o_b_* = A->B), injection, status.
module ucie_d2d_channel_model
   import ucie_d2d_pkg::*;
#(
   parameter int NBYTES  = 8,
   parameter int NC      = 32,
   parameter int MSGW    = 4,
   parameter int MAX_LAT = 8,
   localparam int MBW    = NBYTES * 8,
   localparam int LATW   = $clog2(MAX_LAT + 1)
)(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [LATW-1:0] i_cfg_lat,
   input  logic            i_cfg_link_up,
   input  logic [MBW-1:0]  i_a_data,
   input  logic            i_a_valid,
   input  logic [MSGW-1:0] i_a_sb_msg,
   input  logic            i_a_sb_valid,
   input  logic [NC-1:0]   i_a_sb_data,
   input  logic            i_a_train,
   input  logic [MBW-1:0]  i_b_data,
   input  logic            i_b_valid,
   input  logic [MSGW-1:0] i_b_sb_msg,
   input  logic            i_b_sb_valid,
   input  logic [NC-1:0]   i_b_sb_data,
   input  logic            i_b_train,
   output logic [MBW-1:0]  o_a_data,
   output logic            o_a_valid,
   output logic [MSGW-1:0] o_a_sb_msg,
   output logic            o_a_sb_valid,
   output logic [NC-1:0]   o_a_sb_data,
   output logic            o_a_train,
   output logic [MBW-1:0]  o_b_data,
   output logic            o_b_valid,
   output logic [MSGW-1:0] o_b_sb_msg,
   output logic            o_b_sb_valid,
   output logic [NC-1:0]   o_b_sb_data,
   output logic            o_b_train,
   input  logic            i_inj_req,
   input  logic            i_inj_dir,
   input  logic [MBW-1:0]  i_inj_mask,
   output logic [1:0]      o_inj_busy,
   output logic            o_inj_done,
   output logic [1:0]      o_link_state,
   output logic [31:0]     o_beats_a2b,
   output logic [31:0]     o_beats_b2a
);

   localparam int UGW = 2 + NC + MSGW;

   link_state_e     state, state_nxt;
   logic [LATW-1:0] lat_q, drain_cnt, cnt_nxt;
   logic [1:0]      vin, hit, arm, busy;
   logic [MBW-1:0]  mask [2];
   logic            done_q;
   logic [31:0]     beats_a2b, beats_b2a;
   logic [MBW-1:0]  a2b_data, b2a_data;
   logic [MBW:0]    mb_a2b_out, mb_b2a_out;
   logic [UGW-1:0]  ug_a2b_out, ug_b2a_out;

   assign cnt_nxt = drain_cnt + LATW'(1);

   always_comb begin
      state_nxt = state;
      unique case (state)
         DOWN:    if (i_cfg_link_up) state_nxt = UP;
         UP:      if (!i_cfg_link_up) state_nxt = DRAIN;
         DRAIN:   if (cnt_nxt == lat_q) state_nxt = DOWN;
         default: state_nxt = DOWN;
      endcase
   end

   assign vin[DIR_A2B] = i_a_valid & (state == UP);
   assign vin[DIR_B2A] = i_b_valid & (state == UP);
   assign hit = busy & vin;
   assign arm[DIR_A2B] = i_inj_req & (state == UP) & ~i_inj_dir;
   assign arm[DIR_B2A] = i_inj_req & (state == UP) & i_inj_dir;

   // Gated beats carry zero data so idle output data stays 0.
   always_comb begin
      a2b_data = '0;
      b2a_data = '0;
      if (vin[DIR_A2B])
         a2b_data = i_a_data ^ (hit[DIR_A2B] ? mask[DIR_A2B] : '0);
      if (vin[DIR_B2A])
         b2a_data = i_b_data ^ (hit[DIR_B2A] ? mask[DIR_B2A] : '0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= DOWN;
         lat_q     <= LATW'(1);
         drain_cnt <= '0;
         busy      <= '0;
         done_q    <= 1'b0;
         beats_a2b <= '0;
         beats_b2a <= '0;
         for (int d = 0; d < 2; d++) mask[d] <= '0;
      end else begin
         state     <= state_nxt;
         if (state == DOWN)
            lat_q <= LATW'(clamp_lat(int'(i_cfg_lat), MAX_LAT));
         drain_cnt <= (state == DRAIN) ? cnt_nxt : '0;
         done_q    <= |hit;
         beats_a2b <= beats_a2b + 32'(o_b_valid);
         beats_b2a <= beats_b2a + 32'(o_a_valid);
         // An armed direction can only see its beat next cycle,
         // because busy is still clear during the arming cycle.
         for (int d = 0; d < 2; d++) begin
            if (state_nxt == DOWN) begin
               busy[d] <= 1'b0;
            end else if (hit[d]) begin
               busy[d] <= 1'b0;
            end else if (arm[d] && !busy[d]) begin
               busy[d] <= 1'b1;
               mask[d] <= i_inj_mask;
            end
         end
      end
   end

   ucie_d2d_delay_line #(.W(MBW + 1), .DEPTH(MAX_LAT), .LATW(LATW)) u_mb_a2b (
      .clk(i_clk), .rst_n(i_rst_n), .lat(lat_q),
      .d({vin[DIR_A2B], a2b_data}), .q(mb_a2b_out)
   );

   ucie_d2d_delay_line #(.W(MBW + 1), .DEPTH(MAX_LAT), .LATW(LATW)) u_mb_b2a (
      .clk(i_clk), .rst_n(i_rst_n), .lat(lat_q),
      .d({vin[DIR_B2A], b2a_data}), .q(mb_b2a_out)
   );

   ucie_d2d_delay_line #(.W(UGW), .DEPTH(MAX_LAT), .LATW(LATW)) u_ug_a2b (
      .clk(i_clk), .rst_n(i_rst_n), .lat(lat_q),
      .d({i_a_train, i_a_sb_valid, i_a_sb_data, i_a_sb_msg}),
      .q(ug_a2b_out)
   );

   ucie_d2d_delay_line #(.W(UGW), .DEPTH(MAX_LAT), .LATW(LATW)) u_ug_b2a (
      .clk(i_clk), .rst_n(i_rst_n), .lat(lat_q),
      .d({i_b_train, i_b_sb_valid, i_b_sb_data, i_b_sb_msg}),
      .q(ug_b2a_out)
   );

   assign o_b_valid = mb_a2b_out[MBW] & (state != DOWN);
   assign o_a_valid = mb_b2a_out[MBW] & (state != DOWN);
   assign o_b_data  = o_b_valid ? mb_a2b_out[MBW-1:0] : '0;
   assign o_a_data  = o_a_valid ? mb_b2a_out[MBW-1:0] : '0;

   assign {o_b_train, o_b_sb_valid, o_b_sb_data, o_b_sb_msg} = ug_a2b_out;
   assign {o_a_train, o_a_sb_valid, o_a_sb_data, o_a_sb_msg} = ug_b2a_out;

   assign o_inj_busy   = busy;
   assign o_inj_done   = done_q;
   assign o_link_state = state;
   assign o_beats_a2b  = beats_a2b;
   assign o_beats_b2a  = beats_b2a;

endmodule

// File: tb/tb_ucie_d2d_channel_model.sv
// Directed bench for the die-to-die channel model.
// Beats are queued with their due cycle and checked as they emerge.
module tb_ucie_d2d_channel_model;

   localparam int MBW  = 64;
   localparam int NC   = 32;
   localparam int MSGW = 4;
   localparam int LATW = 4;

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [LATW-1:0] cfg_lat;
   logic            link_up;
   logic [MBW-1:0]  a_data, b_data, oa_data, ob_data;
   logic            a_valid, b_valid, oa_valid, ob_valid;
   logic [MSGW-1:0] a_msg, b_msg, oa_msg, ob_msg;
   logic            a_sbv, b_sbv, oa_sbv, ob_sbv;
   logic [NC-1:0]   a_sbd, b_sbd, oa_sbd, ob_sbd;
   logic            a_train, b_train, oa_train, ob_train;
   logic            inj_req, inj_dir;
   logic [MBW-1:0]  inj_mask;
   logic [1:0]      inj_busy, link_state;
   logic            inj_done;
   logic [31:0]     beats_a2b, beats_b2a;

   int   n_err = 0;
   int   n_chk = 0;
   int   cyc = 0;
   int   exp_a2b = 0;
   int   exp_b2a = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   ucie_d2d_channel_model dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cfg_lat(cfg_lat), .i_cfg_link_up(link_up),
      .i_a_data(a_data), .i_a_valid(a_valid),
      .i_a_sb_msg(a_msg), .i_a_sb_valid(a_sbv),
      .i_a_sb_data(a_sbd), .i_a_train(a_train),
      .i_b_data(b_data), .i_b_valid(b_valid),
      .i_b_sb_msg(b_msg), .i_b_sb_valid(b_sbv),
      .i_b_sb_data(b_sbd), .i_b_train(b_train),
      .o_a_data(oa_data), .o_a_valid(oa_valid),
      .o_a_sb_msg(oa_msg), .o_a_sb_valid(oa_sbv),
      .o_a_sb_data(oa_sbd), .o_a_train(oa_train),
      .o_b_data(ob_data), .o_b_valid(ob_valid),
      .o_b_sb_msg(ob_msg), .o_b_sb_valid(ob_sbv),
      .o_b_sb_data(ob_sbd), .o_b_train(ob_train),
      .i_inj_req(inj_req), .i_inj_dir(inj_dir),
      .i_inj_mask(inj_mask),
      .o_inj_busy(inj_busy), .o_inj_done(inj_done),
      .o_link_state(link_state),
      .o_beats_a2b(beats_a2b), .o_beats_b2a(beats_b2a)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [63:0] d, input logic [63:0] e,
                         input int lat);
      a_valid = 1'b1;
      a_data  = d;
      q_b.push_back('{e, cyc + lat});
      tick();
   endtask

   task automatic send_b(input logic [63:0] d, input logic [63:0] e,
                         input int lat);
      b_valid = 1'b1;
      b_data  = d;
      q_a.push_back('{e, cyc + lat});
      tick();
   endtask

   task automatic wait_down();
      for (int k = 0; k < 20; k++) begin
         if (link_state == 2'd0) break;
         tick();
      end
      chk("reach_down", link_state, 0);
   endtask

   task automatic go_up(input logic [LATW-1:0] cfg);
      cfg_lat = cfg;
      tick();
      link_up = 1'b1;
      tick();
      chk("state_up", link_state, 1);
   endtask

   task automatic burst(input logic [LATW-1:0] cfg, input int eff,
                        input int n, input logic [63:0] base,
                        input bit poke);
      go_up(cfg);
      if (poke) cfg_lat = 4'd5;
      for (int i = 0; i < n; i++) send_a(base + 64'(i), base + 64'(i), eff);
      a_valid = 1'b0;
      repeat (eff + 2) tick();
      chk("burst_q_empty", q_b.size(), 0);
      exp_a2b += n;
      chk("burst_beats", beats_a2b, exp_a2b);
      link_up = 1'b0;
      wait_down();
   endtask

   // Scoreboard: every delivered beat must match the head of the queue
   // in both value and arrival cycle; idle data must read as zero.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ob_valid) begin
            if (q_b.size() == 0) begin
               chk("b_unexpected", ob_valid, 0);
            end else begin
               exp_t e;
               e = q_b.pop_front();
               chk("b_data", ob_data, e.data);
               chk("b_cycle", cyc, e.cyc);
            end
         end else begin
            chk("b_idle_zero", ob_data, 0);
         end
         if (oa_valid) begin
            if (q_a.size() == 0) begin
               chk("a_unexpected", oa_valid, 0);
            end else begin
               exp_t e;
               e = q_a.pop_front();
               chk("a_data", oa_data, e.data);
               chk("a_cycle", cyc, e.cyc);
            end
         end else begin
            chk("a_idle_zero", oa_data, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lats[3];
      lats = '{1, 3, 8};
      rst_n = 0; cfg_lat = 0; link_up = 0;
      a_data = 0; a_valid = 0; a_msg = 0; a_sbv = 0; a_sbd = 0; a_train = 0;
      b_data = 0; b_valid = 0; b_msg = 0; b_sbv = 0; b_sbd = 0; b_train = 0;
      inj_req = 0; inj_dir = 0; inj_mask = 0;
      tick();
      chk("rst_state", link_state, 0);
      chk("rst_beats_a2b", beats_a2b, 0);
      chk("rst_busy", inj_busy, 0);
      chk("rst_b_valid", ob_valid, 0);
      tick();
      rst_n = 1;
      tick();

      // latency sweep
      for (int i = 0; i < 3; i++)
         burst(LATW'(lats[i]), lats[i], 5, 64'hA5A5_0001, 1'b0);

      // clamp: 15 -> 8 with a write of 5 ignored while up, then 0 -> 1
      burst(4'd15, 8, 2, 64'hC0DE_0000, 1'b1);
      burst(4'd0, 1, 3, 64'hC1DE_0000, 1'b0);
      burst(4'd5, 5, 2, 64'hC5DE_0000, 1'b0);

      // drain with 4 beats in flight; valid during drain is dropped
      go_up(4'd4);
      send_a(64'hB1, 64'hB1, 4);
      send_a(64'hB2, 64'hB2, 4);
      send_a(64'hB3, 64'hB3, 4);
      a_data = 64'hB4;
      q_b.push_back('{64'hB4, cyc + 4});
      link_up = 1'b0;
      tick();
      a_data = 64'hDEAD;
      for (int k = 0; k < 4; k++) begin
         chk("drain_state", link_state, 2);
         tick();
      end
      a_valid = 1'b0;
      chk("drain_down", link_state, 0);
      chk("drain_q_empty", q_b.size(), 0);
      exp_a2b += 4;
      chk("drain_beats", beats_a2b, exp_a2b);

      // injection B->A, second arm ignored while busy
      go_up(4'd2);
      inj_req = 1; inj_dir = 1; inj_mask = 64'h1;
      tick();
      inj_req = 0;
      chk("inj_armed", inj_busy, 2'b10);
      inj_req = 1; inj_mask = 64'hFF;
      tick();
      inj_req = 0;
      chk("inj_still_armed", inj_busy, 2'b10);
      chk("inj_no_done", inj_done, 0);
      send_b(64'h10, 64'h11, 2);
      chk("inj_done_pulse", inj_done, 1);
      chk("inj_busy_clear", inj_busy, 0);
      send_b(64'h20, 64'h20, 2);
      b_valid = 0;
      chk("inj_done_single", inj_done, 0);
      // A->B: arm and beat together, only the next beat is hit
      inj_req = 1; inj_dir = 0; inj_mask = 64'hF0;
      send_a(64'h1, 64'h1, 2);
      inj_req = 0;
      chk("inj_a_armed", inj_busy, 2'b01);
      chk("inj_a_no_done", inj_done, 0);
      send_a(64'h2, 64'hF2, 2);
      a_valid = 0;
      chk("inj_a_done", inj_done, 1);
      repeat (4) tick();
      chk("inj_qa_empty", q_a.size(), 0);
      chk("inj_qb_empty", q_b.size(), 0);
      exp_a2b += 2;
      exp_b2a += 2;
      chk("inj_beats_a2b", beats_a2b, exp_a2b);
      chk("inj_beats_b2a", beats_b2a, exp_b2a);
      // an armed direction is disarmed by going down
      inj_req = 1; inj_dir = 0; inj_mask = 64'h1;
      tick();
      inj_req = 0;
      link_up = 0;
      wait_down();
      chk("down_clears_busy", inj_busy, 0);
      chk("down_no_done", inj_done, 0);

      // ungated traffic while down
      cfg_lat = 4'd3;
      tick();
      a_train = 1; a_msg = 4'h3; a_valid = 1; a_data = 64'h77;
      tick();
      a_train = 0; a_msg = 0; a_valid = 0; a_data = 0;
      tick();
      chk("ug_train_early", ob_train, 0);
      tick();
      chk("ug_train", ob_train, 1);
      chk("ug_msg", ob_msg, 4'h3);
      chk("ug_mb_gated", ob_valid, 0);
      tick();
      chk("ug_beats", beats_a2b, exp_a2b);

      // reset mid-burst
      go_up(4'd4);
      for (int i = 0; i < 5; i++) send_a(64'hE0 + 64'(i), 64'hE0 + 64'(i), 4);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", ob_valid, 0);
      chk("mid_rst_data", ob_data, 0);
      chk("mid_rst_beats", beats_a2b, 0);
      chk("mid_rst_state", link_state, 0);
      a_valid = 0; link_up = 0;
      q_b.delete();
      exp_a2b = 0;
      exp_b2a = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
      chk("post_rst_state", link_state, 0);
      chk("post_rst_beats", beats_b2a, 0);
      burst(4'd6, 6, 3, 64'hF000_0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
